psram_cfg_seq: RTL and testbench
================================

PSRAM_CFG_SEQ -- requirements
Module: psram_cfg_seq

Interface
REQ-001 Parameter CLK_MHZ, default 51, integer clock frequency in MHz of clk (the PLL clkout).
REQ-002 Parameter PWRUP_US, default 150, PSRAM power-up wait in microseconds.
REQ-003 Parameter LATENCY, default 3, PSRAM initial latency in clocks; legal values are 3..7.
REQ-004 Port clk, input, 1 bit: the single clock, which is the PLL clkout domain.
REQ-005 Port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 Port cmd_valid, output, 1 bit: register command offered to the PSRAM PHY.
REQ-007 Port cmd_ready, input, 1 bit: PHY accepts the command.
REQ-008 Port cmd_ca, output, 48 bits: HyperBus command/address word.
REQ-009 Port cmd_wdata, output, 16 bits: register write data, which is don't-care on reads.
REQ-010 Port rd_valid, input, 1 bit: single-cycle strobe for register read data.
REQ-011 Port rd_data, input, 16 bits: register read data.
REQ-012 Port init_done, output, 1 bit: configuration complete, sticky until reset.
REQ-013 Port init_err, output, 1 bit: configuration failed, sticky until reset.

Function
REQ-014 The state machine SHALL have the states PWR_WAIT, WR_CR0, RD_CR0, RD_WAIT, DONE and FAIL.
REQ-015 PWR_WAIT SHALL count exactly PWRUP_US*CLK_MHZ cycles (7650 at defaults) and then go to WR_CR0; the counter width is derived with $clog2 of that count.
REQ-016 CR0 SHALL be {1'b1, 3'b000, 4'hF, LC, 1'b1, 1'b1, 2'b11}.
REQ-017 LC SHALL map latency 3->4'b1110, 4->4'b1111, 5->4'b0000, 6->4'b0001, 7->4'b0010, giving CR0=16'h8FEF for latency 3.
REQ-018 WR_CR0 SHALL assert cmd_valid with cmd_ca=48'h6000_0100_0000 and cmd_wdata=CR0.
REQ-019 cmd_valid, cmd_ca and cmd_wdata SHALL stay stable until the cycle in which cmd_valid&&cmd_ready is true.
REQ-020 A command SHALL be accepted on the first cycle with cmd_valid&&cmd_ready; cmd_valid SHALL deassert in the following cycle unless a new command is issued.
REQ-021 After write acceptance, with readback disabled (REQ-030), the FSM SHALL go to DONE on the next cycle.
REQ-022 cmd_valid SHALL NOT assert before the power-up count has elapsed, regardless of cmd_ready.
REQ-023 In DONE, init_done=1, cmd_valid=0, and all other inputs SHALL be ignored.
REQ-024 In FAIL, init_err=1, init_done=0 and cmd_valid=0.
REQ-025 init_done and init_err SHALL never both be 1.
REQ-026 rd_valid SHALL be ignored in every state except RD_WAIT.
REQ-027 An invalid LATENCY value SHALL cause an elaboration-time error.

Reset
REQ-028 On assertion of rst_n (asynchronous, at any time, including mid-handshake), the state SHALL become PWR_WAIT, the counter 0, cmd_valid=0, cmd_ca=0, cmd_wdata=0, init_done=0, init_err=0 and the retry count 0.
REQ-029 After reset deassertion, the full power-up wait SHALL restart from zero.

Configuration
REQ-030 With the macro PSRAM_CFG_READBACK_EN defined, write acceptance SHALL lead to RD_CR0, which issues cmd_ca=48'hE000_0100_0000.
REQ-031 After read acceptance, RD_WAIT SHALL compare rd_data to CR0: a match goes to DONE; a mismatch increments the retry count and returns to WR_CR0.
REQ-032 The third consecutive mismatch SHALL go to FAIL.
REQ-033 Without PSRAM_CFG_READBACK_EN, the RD_CR0 and RD_WAIT states, the retry logic and FAIL SHALL be absent.
REQ-034 Without PSRAM_CFG_READBACK_EN, init_err SHALL be tied to 0 and rd_valid and rd_data SHALL be unused.

Structure
REQ-035 Package psram_pkg SHALL hold the state enum, the CR0 field constants, the 48-bit CA constants for CR0 write and read, and the latency-to-LC function.
REQ-036 The sub-module psram_pwrup_timer SHALL hold the power-up counter, with parameter CYCLES, ports clk, rst_n and out done, where done is sticky.

Verification
REQ-037 Defaults, cmd_ready=1: cmd_valid first rises 7650 cycles after reset release, with cmd_ca=48'h6000_0100_0000 and cmd_wdata=16'h8FEF; init_done=1 two cycles later.
REQ-038 LATENCY=5, cmd_ready held 0 for 20 cycles: cmd_valid/ca/wdata stay stable throughout, cmd_wdata=16'h8F0F, and there is exactly one acceptance.
REQ-039 rst_n pulsed low during the cmd_valid wait: outputs clear immediately, and cmd_valid reappears only after another full power-up count.
REQ-040 PSRAM_CFG_READBACK_EN, rd_data=16'h8FEF: one write and one read are issued, then init_done=1 and init_err=0.
REQ-041 PSRAM_CFG_READBACK_EN, rd_data=16'h0000 always: three write/read pairs are issued, then init_err=1, init_done=0, and no further cmd_valid.
REQ-042 Stray rd_valid pulses during PWR_WAIT and DONE cause no state or output change.

Source files
------------

// File: rtl/psram_pkg.sv
// Shared types and constants for the PSRAM CR0 configuration sequencer.
// The readback states exist only when PSRAM_CFG_READBACK_EN is defined.
package psram_pkg;

`ifdef PSRAM_CFG_READBACK_EN
  typedef enum logic [2:0] {
    PWR_WAIT = 3'd0,
    WR_CR0   = 3'd1,
    RD_CR0   = 3'd2,
    RD_WAIT  = 3'd3,
    DONE     = 3'd4,
    FAIL     = 3'd5
  } state_e;
`else
  typedef enum logic [2:0] {
    PWR_WAIT = 3'd0,
    WR_CR0   = 3'd1,
    DONE     = 3'd4
  } state_e;
`endif

  // CR0 fields, MSB first: deep power-down off, drive strength, reserved,
  // initial latency code, fixed latency, hybrid burst, burst length.
  localparam logic       CR0_DPD_OFF   = 1'b1;
  localparam logic [2:0] CR0_DRIVE     = 3'b000;
  localparam logic [3:0] CR0_RSVD      = 4'hF;
  localparam logic       CR0_FIXED_LAT = 1'b1;
  localparam logic       CR0_HYBRID    = 1'b1;
  localparam logic [1:0] CR0_BURST     = 2'b11;

  localparam logic [47:0] CA_CR0_WR = 48'h6000_0100_0000;
  localparam logic [47:0] CA_CR0_RD = 48'hE000_0100_0000;

  localparam logic [1:0] RETRY_LAST = 2'd2;

  function automatic logic [3:0] lat_to_lc(input int lat);
    logic [3:0] lc;
    case (lat)
      3:       lc = 4'b1110;
      4:       lc = 4'b1111;
      5:       lc = 4'b0000;
      6:       lc = 4'b0001;
      7:       lc = 4'b0010;
      default: lc = 4'b1110;
    endcase
    return lc;
  endfunction

  function automatic logic [15:0] cr0_word(input int lat);
    return {CR0_DPD_OFF, CR0_DRIVE, CR0_RSVD, lat_to_lc(lat),
            CR0_FIXED_LAT, CR0_HYBRID, CR0_BURST};
  endfunction

endpackage

// File: rtl/psram_pwrup_timer.sv
// Power-up wait: counts CYCLES clocks after reset release; done stays high
// because the counter saturates at its terminal count.
module psram_pwrup_timer #(
  parameter int CYCLES = 7650
) (
  input  logic clk,
  input  logic rst_n,
  output logic done
);

  localparam int W = (CYCLES > 1) ? $clog2(CYCLES) : 1;
  localparam logic [W-1:0] TC = W'(CYCLES - 1);

  logic [W-1:0] cnt_q, cnt_d;

  assign done = (cnt_q == TC);

  always_comb begin
    cnt_d = cnt_q;
    if (!done) cnt_d = cnt_q + W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/psram_cfg_seq.sv
// Writes PSRAM CR0 after power-up; PSRAM_CFG_READBACK_EN adds a read-back
// compare with up to three attempts before flagging init_err.
module psram_cfg_seq
  import psram_pkg::*;
#(
  parameter int CLK_MHZ  = 51,
  parameter int PWRUP_US = 150,
  parameter int LATENCY  = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        cmd_valid,
  input  logic        cmd_ready,
  output logic [47:0] cmd_ca,
  output logic [15:0] cmd_wdata,
  input  logic        rd_valid,
  input  logic [15:0] rd_data,
  output logic        init_done,
  output logic        init_err
);

  if (LATENCY < 3 || LATENCY > 7) begin : g_bad_latency
    $error("psram_cfg_seq: LATENCY must be in 3..7");
  end

  localparam logic [15:0] CR0          = cr0_word(LATENCY);
  localparam int          PWRUP_CYCLES = PWRUP_US * CLK_MHZ;

  state_e      state_q, state_d;
  logic        pwrup_done;
  logic        cmd_acc;
  logic        cmd_valid_q, cmd_valid_d;
  logic [47:0] cmd_ca_q, cmd_ca_d;
  logic [15:0] cmd_wdata_q, cmd_wdata_d;
  logic        init_done_q, init_done_d;

  psram_pwrup_timer #(.CYCLES(PWRUP_CYCLES)) u_pwrup_timer (
    .clk  (clk),
    .rst_n(rst_n),
    .done (pwrup_done)
  );

  assign cmd_acc = cmd_valid_q && cmd_ready;

`ifdef PSRAM_CFG_READBACK_EN
  logic [1:0] retry_q, retry_d;
  logic       init_err_q, init_err_d;
`else
  logic unused_rd;
  assign unused_rd = ^{rd_valid, rd_data};
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= PWR_WAIT;
      cmd_valid_q <= 1'b0;
      cmd_ca_q    <= '0;
      cmd_wdata_q <= '0;
      init_done_q <= 1'b0;
`ifdef PSRAM_CFG_READBACK_EN
      retry_q     <= '0;
      init_err_q  <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cmd_valid_q <= cmd_valid_d;
      cmd_ca_q    <= cmd_ca_d;
      cmd_wdata_q <= cmd_wdata_d;
      init_done_q <= init_done_d;
`ifdef PSRAM_CFG_READBACK_EN
      retry_q     <= retry_d;
      init_err_q  <= init_err_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
`ifdef PSRAM_CFG_READBACK_EN
    retry_d = retry_q;
`endif
    case (state_q)
      PWR_WAIT: if (pwrup_done) state_d = WR_CR0;
`ifdef PSRAM_CFG_READBACK_EN
      WR_CR0:   if (cmd_acc) state_d = RD_CR0;
      RD_CR0:   if (cmd_acc) state_d = RD_WAIT;
      RD_WAIT: begin
        if (rd_valid) begin
          if (rd_data == CR0) begin
            state_d = DONE;
          end else begin
            retry_d = retry_q + 2'd1;
            state_d = (retry_q == RETRY_LAST) ? FAIL : WR_CR0;
          end
        end
      end
      FAIL:     state_d = FAIL;
`else
      WR_CR0:   if (cmd_acc) state_d = DONE;
`endif
      DONE:     state_d = DONE;
      default:  state_d = PWR_WAIT;
    endcase
  end

  // Command outputs follow the next state so they are registered yet change
  // in the same cycle as the state, and hold steady while a command waits.
  always_comb begin
    cmd_valid_d = 1'b0;
    cmd_ca_d    = '0;
    cmd_wdata_d = '0;
    case (state_d)
      WR_CR0: begin
        cmd_valid_d = 1'b1;
        cmd_ca_d    = CA_CR0_WR;
        cmd_wdata_d = CR0;
      end
`ifdef PSRAM_CFG_READBACK_EN
      RD_CR0: begin
        cmd_valid_d = 1'b1;
        cmd_ca_d    = CA_CR0_RD;
      end
`endif
      default: ;
    endcase
    init_done_d = (state_q == DONE);
`ifdef PSRAM_CFG_READBACK_EN
    init_err_d  = (state_q == FAIL);
`endif
  end

  assign cmd_valid = cmd_valid_q;
  assign cmd_ca    = cmd_ca_q;
  assign cmd_wdata = cmd_wdata_q;
  assign init_done = init_done_q;
`ifdef PSRAM_CFG_READBACK_EN
  assign init_err  = init_err_q;
`else
  assign init_err  = 1'b0;
`endif

endmodule

// File: tb/tb_psram_cfg_seq.sv
// Directed bench for psram_cfg_seq: a default instance (7650-cycle wait) and
// a short-wait LATENCY=5 instance; readback cases when PSRAM_CFG_READBACK_EN.
module tb_psram_cfg_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_a_n, rdy_a, rdv_a, vld_a, done_a, err_a;
  logic [15:0] rdd_a, wd_a;
  logic [47:0] ca_a;

  logic        rst_b_n, rdy_b, rdv_b, vld_b, done_b, err_b;
  logic [15:0] rdd_b, wd_b;
  logic [47:0] ca_b;

  int checks = 0;
  int errors = 0;
  int wr_a = 0, rd_a = 0, wr_b = 0, rd_b = 0;
  int rise;
  logic flag;

  psram_cfg_seq u_dut_a (
    .clk(clk), .rst_n(rst_a_n), .cmd_valid(vld_a), .cmd_ready(rdy_a),
    .cmd_ca(ca_a), .cmd_wdata(wd_a), .rd_valid(rdv_a), .rd_data(rdd_a),
    .init_done(done_a), .init_err(err_a)
  );

  psram_cfg_seq #(.CLK_MHZ(1), .PWRUP_US(20), .LATENCY(5)) u_dut_b (
    .clk(clk), .rst_n(rst_b_n), .cmd_valid(vld_b), .cmd_ready(rdy_b),
    .cmd_ca(ca_b), .cmd_wdata(wd_b), .rd_valid(rdv_b), .rd_data(rdd_b),
    .init_done(done_b), .init_err(err_b)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Acceptances are counted just before the edge that takes them.
  task automatic step_a();
    if (vld_a && rdy_a) begin
      if (ca_a[47]) rd_a++;
      else          wr_a++;
    end
    tick();
  endtask

  task automatic step_b();
    if (vld_b && rdy_b) begin
      if (ca_b[47]) rd_b++;
      else          wr_b++;
    end
    tick();
  endtask

  // Returns the edge number (1 = first edge after release) of cmd_valid rise.
  task automatic run_to_rise_a(input logic strays, output int edge_n);
    edge_n = 0;
    for (int e = 1; e <= 8000; e++) begin
      if (strays) begin
        rdv_a = (e % 7 == 0);
        rdd_a = 16'($urandom);
      end
      step_a();
      if (vld_a) begin
        edge_n = e;
        break;
      end
    end
    rdv_a = 1'b0;
  endtask

  task automatic finish_a();
    rdy_a = 1'b1;
    rdv_a = 1'b1;
    rdd_a = 16'h8FEF;
    for (int i = 0; i < 20 && !done_a; i++) step_a();
    rdv_a = 1'b0;
  endtask

  initial begin
    rst_a_n = 1'b0; rdy_a = 1'b0; rdv_a = 1'b0; rdd_a = '0;
    rst_b_n = 1'b0; rdy_b = 1'b0; rdv_b = 1'b0; rdd_b = '0;
    tick();
    tick();
    chk("rst_valid", 64'(vld_a), 64'd0);
    chk("rst_ca", 64'(ca_a), 64'd0);
    chk("rst_wdata", 64'(wd_a), 64'd0);
    chk("rst_done", 64'(done_a), 64'd0);
    chk("rst_err", 64'(err_a), 64'd0);

    // LATENCY=5 instance: stall with cmd_ready low for 20 cycles
    rst_b_n = 1'b1;
    flag = 1'b0;
    for (int e = 1; e <= 19; e++) begin
      step_b();
      if (vld_b) flag = 1'b1;
    end
    chk("b_early_valid", 64'(flag), 64'd0);
    step_b();
    chk("b_rise_valid", 64'(vld_b), 64'd1);
    chk("b_rise_ca", 64'(ca_b), 64'h6000_0100_0000);
    chk("b_rise_wdata", 64'(wd_b), 64'h8F0F);
    for (int i = 0; i < 20; i++) begin
      step_b();
      chk("b_stall_valid", 64'(vld_b), 64'd1);
      chk("b_stall_ca", 64'(ca_b), 64'h6000_0100_0000);
      chk("b_stall_wdata", 64'(wd_b), 64'h8F0F);
    end
    chk("b_stall_no_acc", 64'(wr_b), 64'd0);
    rdy_b = 1'b1;
`ifndef PSRAM_CFG_READBACK_EN
    step_b();
    chk("b_valid_drop", 64'(vld_b), 64'd0);
    step_b();
    chk("b_done", 64'(done_b), 64'd1);
    for (int i = 0; i < 5; i++) step_b();
    chk("b_one_accept", 64'(wr_b), 64'd1);
`else
    // Readback, matching data (CR0 = 8F0F at LATENCY 5)
    rst_b_n = 1'b0; #1; rst_b_n = 1'b1;
    wr_b = 0; rd_b = 0;
    rdv_b = 1'b1; rdd_b = 16'h8F0F;
    for (int i = 0; i < 60; i++) step_b();
    chk("rb_ok_writes", 64'(wr_b), 64'd1);
    chk("rb_ok_reads", 64'(rd_b), 64'd1);
    chk("rb_ok_done", 64'(done_b), 64'd1);
    chk("rb_ok_err", 64'(err_b), 64'd0);

    // Readback, data never matches: three attempts then FAIL
    rst_b_n = 1'b0; #1; rst_b_n = 1'b1;
    wr_b = 0; rd_b = 0;
    rdd_b = 16'h0000;
    flag = 1'b0;
    for (int i = 0; i < 80; i++) begin
      step_b();
      if (err_b && vld_b) flag = 1'b1;
    end
    chk("rb_bad_writes", 64'(wr_b), 64'd3);
    chk("rb_bad_reads", 64'(rd_b), 64'd3);
    chk("rb_bad_err", 64'(err_b), 64'd1);
    chk("rb_bad_done", 64'(done_b), 64'd0);
    chk("rb_bad_valid_after", 64'(flag | vld_b), 64'd0);
    rdv_b = 1'b0;
`endif

    // Default instance: full wait with stray rd_valid, cmd_ready held high
    rdy_a = 1'b1;
    rst_a_n = 1'b1;
    run_to_rise_a(1'b1, rise);
    chk("a_rise_edge", 64'(rise), 64'd7650);
    chk("a_rise_ca", 64'(ca_a), 64'h6000_0100_0000);
    chk("a_rise_wdata", 64'(wd_a), 64'h8FEF);
    chk("a_rise_done", 64'(done_a), 64'd0);
`ifndef PSRAM_CFG_READBACK_EN
    step_a();
    chk("a_acc_valid", 64'(vld_a), 64'd0);
    chk("a_acc_done", 64'(done_a), 64'd0);
    step_a();
    chk("a_done_2cyc", 64'(done_a), 64'd1);
`else
    finish_a();
    chk("a_rb_done", 64'(done_a), 64'd1);
`endif
    chk("a_err", 64'(err_a), 64'd0);

    // Stray rd_valid in DONE must change nothing
    flag = 1'b0;
    for (int i = 0; i < 10; i++) begin
      rdv_a = (i % 2 == 0);
      rdd_a = 16'($urandom);
      step_a();
      if (vld_a || !done_a || err_a || ca_a != 48'd0) flag = 1'b1;
    end
    rdv_a = 1'b0;
    chk("a_done_stray", 64'(flag), 64'd0);
    chk("a_one_write", 64'(wr_a), 64'd1);

    // Reset pulse while a command waits for cmd_ready
    rst_a_n = 1'b0; rdy_a = 1'b0; #1;
    rst_a_n = 1'b1;
    run_to_rise_a(1'b0, rise);
    chk("a2_rise_edge", 64'(rise), 64'd7650);
    for (int i = 0; i < 3; i++) step_a();
    chk("a2_wait_valid", 64'(vld_a), 64'd1);
    #2 rst_a_n = 1'b0;
    #1;
    chk("a2_async_valid", 64'(vld_a), 64'd0);
    chk("a2_async_ca", 64'(ca_a), 64'd0);
    chk("a2_async_wdata", 64'(wd_a), 64'd0);
    chk("a2_async_done", 64'(done_a), 64'd0);
    tick();
    rst_a_n = 1'b1;
    run_to_rise_a(1'b0, rise);
    chk("a2_rerise_edge", 64'(rise), 64'd7650);
    finish_a();
    chk("a2_final_done", 64'(done_a), 64'd1);
    chk("a2_final_err", 64'(err_a), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
